// File: rtl/alu_seq_param.sv
// alu_seq_param: registered, parametrised ALU with a persistent Z/C/N/V status
// register and a valid/ready request handshake. Results and status update at the
// accept edge for single-cycle ops; out_valid pulses for the following cycle.
// Optional feature macro: ALU_SEQ_MUL_EN. When defined, op 4'hC is an
// iterative shift-add unsigned multiplier (one bit per cycle, 2*WIDTH-bit product
// split over result/result_hi). When undefined, op 4'hC is a NOP, result_hi and
// busy are constant 0 and in_ready is constant 1.
module alu_seq_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       sreg,
  output logic             busy
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SBC = 4'h4;
  localparam logic [3:0] OP_CMP = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam int MSB = WIDTH - 1;

  // Registered outputs
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_sreg;
  logic             r_out_valid;

  // Single-cycle datapath
  logic             w_carry_in;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_zn_en;
  logic             w_cmp_z;
  logic [3:0]       w_sreg;

  // ADC/SBC consume the carry/borrow left by the previous completed op.
  assign w_carry_in = ((op == OP_ADC) || (op == OP_SBC)) ? r_sreg[1] : 1'b0;
  assign w_sum  = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, w_carry_in};
  // Bit WIDTH of the extended difference is set exactly when A < B + carry_in.
  assign w_diff = {1'b0, operand_a} - {1'b0, operand_b} - {{WIDTH{1'b0}}, w_carry_in};

  // Decode the op into next result and raw flag terms for single-cycle ops.
  always_comb begin
    w_res   = r_result;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_zn_en = 1'b1;
    w_cmp_z = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (operand_a[MSB] == operand_b[MSB]) && (w_sum[MSB] != operand_a[MSB]);
      end
      OP_SUB, OP_SBC: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (operand_a[MSB] != operand_b[MSB]) && (w_diff[MSB] != operand_a[MSB]);
      end
      OP_CMP: begin
        w_zn_en = 1'b0;
        w_cmp_z = ($signed(operand_a) <= $signed(operand_b));
      end
      OP_OR:  w_res = operand_a | operand_b;
      OP_AND: w_res = operand_a & operand_b;
      OP_XOR: w_res = operand_a ^ operand_b;
      OP_SHL: begin
        w_res = {operand_a[WIDTH-2:0], 1'b0};
        w_c   = operand_a[MSB];
      end
      OP_SHR: begin
        w_res = {1'b0, operand_a[WIDTH-1:1]};
        w_c   = operand_a[0];
      end
      OP_ASR: begin
        w_res = {operand_a[MSB], operand_a[WIDTH-1:1]};
        w_c   = operand_a[0];
      end
      default: begin
        // NOP, 4'hD-4'hF (and 4'hC without the multiplier): clear status, hold result.
        w_zn_en = 1'b0;
      end
    endcase
  end

  // Assemble the status word {V,N,C,Z}; CMP and NOP only ever drive Z.
  always_comb begin
    w_sreg = 4'b0000;
    if (w_zn_en) begin
      w_sreg = {w_v, w_res[MSB], w_c, (w_res == {WIDTH{1'b0}})};
    end else begin
      w_sreg = {3'b000, w_cmp_z};
    end
  end

  assign result    = r_result;
  assign sreg      = r_sreg;
  assign out_valid = r_out_valid;

`ifdef ALU_SEQ_MUL_EN

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_busy;
  logic [WIDTH-1:0]   r_result_hi;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_step_sum;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_hold_hi;

  // Only a NOP-class op keeps the previous MUL high half visible.
  assign w_hold_hi  = (op == OP_NOP) || (op > OP_MUL);
  assign w_step_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
  assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  // One shift-add step: the multiplier sits in the low half and is consumed LSB first.
  always_comb begin
    w_prod_next = r_prod;
    if (r_prod[0]) begin
      w_prod_next = {w_step_sum, r_prod[WIDTH-1:1]};
    end else begin
      w_prod_next = {1'b0, r_prod[2*WIDTH-1:1]};
    end
  end

  // Control FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_sreg      <= 4'b0000;
      r_mcand     <= {WIDTH{1'b0}};
      r_prod      <= {(2*WIDTH){1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out_valid <= 1'b0;
          if (in_valid) begin
            if (op == OP_MUL) begin
              r_state    <= ST_MUL;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
              r_mcand    <= operand_a;
              r_prod     <= {{WIDTH{1'b0}}, operand_b};
              r_cnt      <= {CNT_W{1'b0}};
            end else begin
              r_result    <= w_res;
              r_sreg      <= w_sreg;
              r_out_valid <= 1'b1;
              if (!w_hold_hi) begin
                r_result_hi <= {WIDTH{1'b0}};
              end
            end
          end
        end
        ST_MUL: begin
          r_prod      <= w_prod_next;
          r_cnt       <= w_cnt_next;
          r_out_valid <= 1'b0;
          // The WIDTH-th step completes the product; publish it on this edge.
          if (w_cnt_next == CNT_W'(WIDTH)) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_prod_next[WIDTH-1:0];
            r_result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
            r_sreg      <= {2'b00,
                            (w_prod_next[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}}),
                            (w_prod_next == {(2*WIDTH){1'b0}})};
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign result_hi = r_result_hi;

`else

  // Counter width only matters when the multiplier is built.
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = {CNT_W{1'b0}};

  // Every op is single-cycle: update result/status at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_sreg      <= 4'b0000;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_res;
        r_sreg   <= w_sreg;
      end
    end
  end

  assign in_ready  = 1'b1;
  assign busy      = 1'b0;
  assign result_hi = {WIDTH{1'b0}};

`endif

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed-vector bench for alu_seq_param (WIDTH=8). Multiplier expectations
// follow ALU_SEQ_MUL_EN; without it op 4'hC is checked as a NOP.
module tb_alu_seq_param;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       out_valid;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [3:0] sreg;
  logic       busy;

  int n_checks;
  int n_errors;

  alu_seq_param #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result    (result),
    .result_hi (result_hi),
    .sreg      (sreg),
    .busy      (busy)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one op at the falling edge, let it be accepted, sample 1ns after the edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp_res, input logic [3:0] exp_sreg);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".sreg"}, sreg, exp_sreg);
    chk({tag, ".out_valid"}, out_valid, 1'b1);
  endtask

`ifdef ALU_SEQ_MUL_EN
  // Accept a MUL and measure edges after the accept edge until out_valid.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                         input logic [3:0] exp_sreg);
    int lat;
    int ready_low;
    issue(4'hC, a, b);
    lat = 0;
    ready_low = 0;
    chk({tag, ".busy_after_accept"}, busy, 1'b1);
    chk({tag, ".ov_after_accept"}, out_valid, 1'b0);
    if (!in_ready) ready_low++;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      if (!in_ready) ready_low++;
    end
    chk({tag, ".latency"}, lat, 8);
    chk({tag, ".ready_low_cycles"}, ready_low, 8);
    chk({tag, ".result"}, result, exp_lo);
    chk({tag, ".result_hi"}, result_hi, exp_hi);
    chk({tag, ".sreg"}, sreg, exp_sreg);
    chk({tag, ".in_ready_done"}, in_ready, 1'b1);
    chk({tag, ".busy_done"}, busy, 1'b0);
  endtask
`endif

  initial begin
    int ov_seen;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 4'h0;
    operand_a = 8'h00;
    operand_b = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.result", result, 8'h00);
    chk("rst.result_hi", result_hi, 8'h00);
    chk("rst.sreg", sreg, 4'h0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Signed overflow on ADD, pulse lasts one cycle
    issue(4'h1, 8'h7F, 8'h01);
    chk_out("add_ovf", 8'h80, 4'b1100);
    @(posedge clk);
    #1;
    chk("add_ovf.pulse_end", out_valid, 1'b0);

    // Borrow, then NOP clears status but keeps result
    issue(4'h2, 8'h00, 8'h01);
    chk_out("sub_borrow", 8'hFF, 4'b0110);
    issue(4'h0, 8'h12, 8'h34);
    chk_out("nop", 8'hFF, 4'b0000);

    // Carry-out feeds a back-to-back ADC
    issue(4'h1, 8'hFF, 8'h01);
    chk_out("add_carry", 8'h00, 4'b0011);
    issue(4'h3, 8'h00, 8'h00);
    chk_out("adc", 8'h01, 4'b0000);

    // Signed compare leaves result alone
    issue(4'h5, 8'h80, 8'h01);
    chk_out("cmp_le", 8'h01, 4'b0001);
    issue(4'h5, 8'h05, 8'h80);
    chk_out("cmp_gt", 8'h01, 4'b0000);

    // Borrow-chained SBC: 5 - 2 - 1
    issue(4'h2, 8'h00, 8'h01);
    issue(4'h4, 8'h05, 8'h02);
    chk_out("sbc", 8'h02, 4'b0000);

    // SUB overflow: negative minus positive giving positive
    issue(4'h2, 8'h80, 8'h01);
    chk_out("sub_ovf", 8'h7F, 4'b1000);

    // Logic and shifts
    issue(4'h8, 8'hF0, 8'hFF);
    chk_out("xor", 8'h0F, 4'b0000);
    issue(4'h7, 8'hF0, 8'h0F);
    chk_out("and_zero", 8'h00, 4'b0001);
    issue(4'h6, 8'h80, 8'h01);
    chk_out("or", 8'h81, 4'b0100);
    issue(4'h9, 8'h81, 8'h00);
    chk_out("shl", 8'h02, 4'b0010);
    issue(4'hA, 8'h81, 8'h00);
    chk_out("shr", 8'h40, 4'b0010);
    issue(4'hB, 8'h81, 8'h00);
    chk_out("asr", 8'hC0, 4'b0110);

`ifdef ALU_SEQ_MUL_EN
    run_mul("mul_0f_11", 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0000);
    run_mul("mul_ff_ff", 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010);
    issue(4'h0, 8'h00, 8'h00);
    chk("nop_after_mul.result_hi", result_hi, 8'hFE);
    chk_out("nop_after_mul", 8'h01, 4'b0000);
    issue(4'h1, 8'h01, 8'h01);
    chk("add_after_mul.result_hi", result_hi, 8'h00);
    chk_out("add_after_mul", 8'h02, 4'b0000);

    // Asynchronous reset in the middle of a MUL
    issue(4'hC, 8'h0F, 8'h11);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mul_rst.in_ready", in_ready, 1'b1);
    chk("mul_rst.busy", busy, 1'b0);
    chk("mul_rst.result", result, 8'h00);
    chk("mul_rst.sreg", sreg, 4'h0);
    chk("mul_rst.result_hi", result_hi, 8'h00);
    chk("mul_rst.out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    op        = 4'h1;
    operand_a = 8'h02;
    operand_b = 8'h03;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_out("add_after_rst", 8'h05, 4'b0000);
    ov_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    chk("mul_rst.no_late_valid", ov_seen, 0);
    chk("mul_rst.result_kept", result, 8'h05);
`else
    // Without the multiplier, op C is a single-cycle NOP
    issue(4'hC, 8'h0F, 8'h11);
    chk_out("mul_as_nop", 8'hC0, 4'b0000);
    chk("mul_as_nop.result_hi", result_hi, 8'h00);
    chk("mul_as_nop.in_ready", in_ready, 1'b1);
    chk("mul_as_nop.busy", busy, 1'b0);
    ov_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    chk("mul_as_nop.no_late_valid", ov_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
